// File: rtl/spi_master_pkg.sv
// spi_master_pkg
// Shared definitions for the multi-mode SPI master:
//   - FSM state encodings and the state width seen on o_spi_state
//   - default CS setup/hold delay in system clocks
//   - CPOL/CPHA mode constants (MODE0..MODE3)
package spi_master_pkg;

  localparam int STATE_W       = 3;
  localparam int DEFAULT_DELAY = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
// Half-period and toggle counters that produce the SPI clock during SHIFT.
// Ports:
//   clk_i, rst_i  system clock, synchronous active-high reset
//   run_i         high while the FSM is in SHIFT; low clears all counters
//   cpol_i        latched idle level of the SPI clock
//   div_i         half-period length minus one, in system clocks
//   len_i         frame length in bits (already clamped to 1..DATA_WIDTH)
//   spi_clk_o     SPI clock level
//   lead_o        strobe: this edge is an odd (leading) toggle
//   trail_o       strobe: this edge is an even (trailing) toggle
//   done_o        strobe: this edge is the final toggle of the frame
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int LW        = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic                 cpol_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [LW-1:0]        len_i,
  output logic                 spi_clk_o,
  output logic                 lead_o,
  output logic                 trail_o,
  output logic                 done_o
);

  localparam int TW = LW + 1;

  logic [DIV_WIDTH-1:0] hp_q, hp_d;
  logic [TW-1:0]        tog_q, tog_d;
  logic                 phase_q, phase_d;
  logic                 tick;
  logic [TW-1:0]        last_tog;

  assign tick     = run_i && (hp_q == div_i);
  assign last_tog = {len_i, 1'b0} - 1'b1;

  // tog_q holds the number of toggles already made, so an even count means
  // the coming toggle is odd-numbered (leading edge)
  assign lead_o    = tick && !tog_q[0];
  assign trail_o   = tick &&  tog_q[0];
  assign done_o    = tick && (tog_q == last_tog);
  assign spi_clk_o = cpol_i ^ phase_q;

  always_comb begin
    hp_d    = hp_q;
    tog_d   = tog_q;
    phase_d = phase_q;
    if (!run_i) begin
      hp_d    = '0;
      tog_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      hp_d    = '0;
      tog_d   = tog_q + 1'b1;
      phase_d = ~phase_q;
    end else begin
      hp_d    = hp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hp_q    <= '0;
      tog_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      hp_q    <= hp_d;
      tog_q   <= tog_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc
// SPI master with runtime CPOL/CPHA, clock divider, frame length and
// chip-select choice. One command is accepted per frame on a valid/ready
// handshake; every command field is latched at accept.
// Ports:
//   i_clk, i_fRST         system clock, synchronous active-high reset
//   i_spi_start, o_ready  command handshake
//   i_cs_sel, i_cpol, i_cpha, i_div, i_len, i_mosi_data  command fields
//   miso                  SPI data in
//   o_miso_data, o_miso_valid  last received frame and its update strobe
//   mosi, cs, spi_clk     SPI pins (cs active low)
//   o_spi_state           current FSM state
module spi_master_mc
  import spi_master_pkg::*;
#(
  parameter  int DATA_WIDTH = 24,
  parameter  int NUM_CS     = 2,
  parameter  int DIV_WIDTH  = 8,
  parameter  int DELAY      = DEFAULT_DELAY,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  i_spi_start,
  output logic                  o_ready,
  input  logic [CSW-1:0]        i_cs_sel,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [DIV_WIDTH-1:0]  i_div,
  input  logic [LW-1:0]         i_len,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_miso_valid,
  output logic                  mosi,
  output logic [NUM_CS-1:0]     cs,
  output logic                  spi_clk,
  output logic [STATE_W-1:0]    o_spi_state
);

  localparam int              DCW      = $clog2(DELAY + 1);
  localparam logic [DCW-1:0]  DLY_LAST = DCW'(DELAY - 1);
  localparam logic [LW-1:0]   LEN_MAX  = LW'(DATA_WIDTH);
  localparam logic [CSW-1:0]  CS_LAST  = CSW'(NUM_CS - 1);

  state_e                  state_q, state_d;
  logic [DCW-1:0]          dly_q, dly_d;
  logic [CSW-1:0]          cs_sel_q;
  logic                    cpol_q, cpha_q, first_q;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [LW-1:0]           len_q;
  logic [DATA_WIDTH-1:0]   tx_q, rx_q, miso_data_q;
  logic                    accept, active;
  logic [LW-1:0]           len_eff;
  logic                    clk_lead, clk_trail, clk_done;
  logic                    tx_shift, rx_sample;

  assign accept  = (state_q == ST_IDLE) && i_spi_start;
  assign len_eff = ((i_len == '0) || (i_len > LEN_MAX)) ? LEN_MAX : i_len;

  // CPHA=1 presents bit L-1 at the first leading edge, which is what the
  // register already holds, so that one edge must not shift
  assign tx_shift  = cpha_q ? (clk_lead && !first_q) : (clk_trail && !clk_done);
  assign rx_sample = cpha_q ? clk_trail : clk_lead;

  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .LW        (LW)
  ) u_clk_gen (
    .clk_i     (i_clk),
    .rst_i     (i_fRST),
    .run_i     (state_q == ST_SHIFT),
    .cpol_i    (cpol_q),
    .div_i     (div_q),
    .len_i     (len_q),
    .spi_clk_o (spi_clk),
    .lead_o    (clk_lead),
    .trail_o   (clk_trail),
    .done_o    (clk_done)
  );

  // Next state and the outputs that depend only on the current state.
  // dly_d defaults to zero so the setup/hold counter restarts on each entry.
  always_comb begin
    state_d      = state_q;
    dly_d        = '0;
    o_ready      = 1'b0;
    o_miso_valid = 1'b0;
    active       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_spi_start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        active = 1'b1;
        if (dly_q == DLY_LAST) state_d = ST_SHIFT;
        else                   dly_d   = dly_q + 1'b1;
      end
      ST_SHIFT: begin
        active = 1'b1;
        if (clk_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        active = 1'b1;
        if (dly_q == DLY_LAST) state_d = ST_DONE;
        else                   dly_d   = dly_q + 1'b1;
      end
      ST_DONE: begin
        o_miso_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cs = '1;
    if (active) cs[cs_sel_q] = 1'b0;
    mosi = active & tx_q[DATA_WIDTH-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_fRST) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  // Command latch plus TX/RX shift registers. TX is left-aligned so the
  // bit on the pin is always the MSB regardless of frame length.
  always_ff @(posedge i_clk) begin
    if (i_fRST) begin
      cs_sel_q    <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      first_q     <= 1'b0;
      div_q       <= '0;
      len_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
    end else begin
      if (accept) begin
        cs_sel_q <= (i_cs_sel > CS_LAST) ? CS_LAST : i_cs_sel;
        cpol_q   <= i_cpol;
        cpha_q   <= i_cpha;
        div_q    <= i_div;
        len_q    <= len_eff;
        tx_q     <= i_mosi_data << (LEN_MAX - len_eff);
        rx_q     <= '0;
        first_q  <= 1'b1;
      end else begin
        if (clk_lead)  first_q <= 1'b0;
        if (tx_shift)  tx_q    <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        if (rx_sample) rx_q    <= {rx_q[DATA_WIDTH-2:0], miso};
      end
      if ((state_q == ST_HOLD) && (state_d == ST_DONE)) miso_data_q <= rx_q;
    end
  end

  assign o_miso_data = miso_data_q;
  assign o_spi_state = state_q;

endmodule

// File: tb/tb_spi_master_mc.sv
`timescale 1ns/100ps
// tb_spi_master_mc
// Self-checking bench: an SPI slave model watches the pins on the falling
// system clock, records MOSI on its sampling edges and drives MISO from its
// own word; each scenario task compares frame results against values
// computed from the frame parameters.
module tb_spi_master_mc;
  import spi_master_pkg::*;

  localparam int DW  = 24;
  localparam int NCS = 2;
  localparam int DLY = 5;
  localparam int CSW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            o_ready;
  logic [CSW-1:0]  cs_sel = '0;
  logic            cpol = 1'b0;
  logic            cpha = 1'b0;
  logic [7:0]      div = '0;
  logic [4:0]      len = '0;
  logic [DW-1:0]   mosi_data = '0;
  logic            miso;
  logic [DW-1:0]   o_miso_data;
  logic            o_miso_valid;
  logic            mosi;
  logic [NCS-1:0]  cs;
  logic            spi_clk;
  logic [2:0]      o_spi_state;

  int checks = 0;
  int failures = 0;

  // slave model configuration (written by scenario tasks only)
  logic            mon_cpha = 1'b0;
  int              mon_sel = 0;
  int              mon_len = 24;
  logic [DW-1:0]   slave_word = '0;
  logic            loop_en = 1'b0;
  logic            slave_miso = 1'b0;

  // slave model observations (written by the monitor only)
  int              frame_cnt = 0, cs_low_cyc = 0, edge_cnt = 0, fall_cnt = 0;
  int              sample_cnt = 0, gap_last = 0, high_run = 0, cs_bad = 0;
  int              mosi_idle_bad = 0, valid_cnt = 0;
  logic [DW-1:0]   slave_rx = '0, rx_at_valid = '0;
  logic            sclk_at_valid = 1'b0, cs_high_at_valid = 1'b0;
  logic [2:0]      state_at_valid = '0;
  logic            prev_act = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;

  assign miso = loop_en ? mosi : slave_miso;

  always #2.5 clk = ~clk;

  spi_master_mc dut (
    .i_clk        (clk),
    .i_fRST       (rst),
    .i_spi_start  (start),
    .o_ready      (o_ready),
    .i_cs_sel     (cs_sel),
    .i_cpol       (cpol),
    .i_cpha       (cpha),
    .i_div        (div),
    .i_len        (len),
    .i_mosi_data  (mosi_data),
    .miso         (miso),
    .o_miso_data  (o_miso_data),
    .o_miso_valid (o_miso_valid),
    .mosi         (mosi),
    .cs           (cs),
    .spi_clk      (spi_clk),
    .o_spi_state  (o_spi_state)
  );

  // SPI slave model: counts clock edges while selected, samples MOSI on
  // its sampling edges, shifts its own word out MSB first on MISO
  always @(negedge clk) begin
    logic           act;
    logic [NCS-1:0] want_cs;
    act     = (cs != '1);
    want_cs = ~(NCS'(1) << mon_sel);
    if (act && !prev_act) begin
      frame_cnt++;
      gap_last   = high_run;
      cs_low_cyc = 0;
      edge_cnt   = 0;
      fall_cnt   = 0;
      sample_cnt = 0;
      slave_rx   = '0;
      cs_bad     = 0;
    end
    if (act) begin
      cs_low_cyc++;
      high_run = 0;
      if (cs != want_cs) cs_bad++;
      if (prev_act && (spi_clk != prev_sclk)) begin
        edge_cnt++;
        if (prev_sclk && !spi_clk) fall_cnt++;
        if (((edge_cnt % 2) == 1) == !mon_cpha) begin
          slave_rx = {slave_rx[DW-2:0], prev_mosi};
          sample_cnt++;
        end
      end
    end else begin
      high_run++;
      if (mosi !== 1'b0) mosi_idle_bad++;
    end
    if (o_miso_valid) begin
      valid_cnt++;
      rx_at_valid      = o_miso_data;
      sclk_at_valid    = spi_clk;
      cs_high_at_valid = (cs == '1);
      state_at_valid   = o_spi_state;
    end
    slave_miso = (sample_cnt < mon_len) ? slave_word[mon_len-1-sample_cnt] : 1'b0;
    prev_act  = act;
    prev_sclk = spi_clk;
    prev_mosi = mosi;
  end

  // reference rules for frame length, data mask and cs-low duration
  function automatic int leff(input int l);
    return ((l == 0) || (l > DW)) ? DW : l;
  endfunction

  function automatic logic [DW-1:0] lmask(input int l);
    return (l >= DW) ? {DW{1'b1}} : ((DW'(1) << l) - DW'(1));
  endfunction

  function automatic int frame_cycles(input int d, input int l);
    return 2 * DLY + 2 * leff(l) * (d + 1);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic p_cpol, input logic p_cpha, input int p_div,
                      input int p_len, input int p_sel, input logic [DW-1:0] p_data,
                      input logic [DW-1:0] p_slave, input bit p_loop);
    int n;
    int sel_seen;
    n = 0;
    while (!o_ready && n < 2000) begin
      tick();
      n++;
    end
    sel_seen   = p_sel % (1 << CSW);
    mon_cpha   = p_cpha;
    mon_sel    = (sel_seen >= NCS) ? NCS - 1 : sel_seen;
    mon_len    = leff(p_len);
    slave_word = p_slave;
    loop_en    = p_loop;
    cpol       = p_cpol;
    cpha       = p_cpha;
    div        = 8'(p_div);
    len        = 5'(p_len);
    cs_sel     = CSW'(p_sel);
    mosi_data  = p_data;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    int n;
    n = 0;
    while (valid_cnt < target && n < 6000) begin
      tick();
      n++;
    end
    checks++;
    if (valid_cnt < target) begin
      failures++;
      $display("[TB] FAIL valid_timeout got=%0d want=%0d", valid_cnt, target);
    end
  endtask

  task automatic test_reset();
    logic [DW+8:0] obs, exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {o_ready, cs, spi_clk, mosi, o_miso_valid, o_spi_state, o_miso_data};
    exp = {1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0, {DW{1'b0}}};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mode2_loopback();
    int v0;
    v0 = valid_cnt;
    send(MODE2.cpol, MODE2.cpha, 3, 0, 0, 24'h188000, '0, 1'b1);
    wait_valid(v0 + 1);
    repeat (5) tick();
    checks++;
    if (cs_low_cyc != 202) begin
      failures++;
      $display("[TB] FAIL m2_cs_low got=%0d want=202", cs_low_cyc);
    end
    checks++;
    if (fall_cnt != 24) begin
      failures++;
      $display("[TB] FAIL m2_falls got=%0d want=24", fall_cnt);
    end
    checks++;
    if (rx_at_valid !== 24'h188000) begin
      failures++;
      $display("[TB] FAIL m2_rx got=%h want=188000", rx_at_valid);
    end
    checks++;
    if (valid_cnt != v0 + 1) begin
      failures++;
      $display("[TB] FAIL m2_valid_count got=%0d want=%0d", valid_cnt, v0 + 1);
    end
    checks++;
    if ({sclk_at_valid, cs_high_at_valid, state_at_valid} !== {1'b1, 1'b1, 3'd4}) begin
      failures++;
      $display("[TB] FAIL m2_done_state got=%b%b%0d want=1 1 4",
               sclk_at_valid, cs_high_at_valid, state_at_valid);
    end
  endtask

  task automatic test_mode1();
    int v0;
    v0 = valid_cnt;
    send(MODE1.cpol, MODE1.cpha, 0, 8, 1, 24'h0000A5, 24'h0000FF, 1'b0);
    wait_valid(v0 + 1);
    checks++;
    if (slave_rx !== 24'h0000A5) begin
      failures++;
      $display("[TB] FAIL m1_mosi_bits got=%h want=0000a5", slave_rx);
    end
    checks++;
    if (rx_at_valid !== 24'h0000FF) begin
      failures++;
      $display("[TB] FAIL m1_rx got=%h want=0000ff", rx_at_valid);
    end
    checks++;
    if (cs_bad != 0) begin
      failures++;
      $display("[TB] FAIL m1_cs_pattern got=%0d bad cycles want=0", cs_bad);
    end
    checks++;
    if ((cs_low_cyc != 26) || (edge_cnt != 16)) begin
      failures++;
      $display("[TB] FAIL m1_timing got=%0d/%0d want=26/16", cs_low_cyc, edge_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0, n;
    logic [DW-1:0] first_rx;
    v0 = valid_cnt;
    f0 = frame_cnt;
    send(MODE0.cpol, MODE0.cpha, 1, 24, 0, 24'h123456, '0, 1'b1);
    start     = 1'b1;
    mosi_data = 24'h654321;
    wait_valid(v0 + 1);
    first_rx = rx_at_valid;
    n = 0;
    while (frame_cnt < f0 + 2 && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_valid(v0 + 2);
    repeat (5) tick();
    checks++;
    if (first_rx !== 24'h123456) begin
      failures++;
      $display("[TB] FAIL b2b_rx1 got=%h want=123456", first_rx);
    end
    checks++;
    if (rx_at_valid !== 24'h654321) begin
      failures++;
      $display("[TB] FAIL b2b_rx2 got=%h want=654321", rx_at_valid);
    end
    checks++;
    if (gap_last != 2) begin
      failures++;
      $display("[TB] FAIL b2b_gap got=%0d want=2", gap_last);
    end
    checks++;
    if (valid_cnt != v0 + 2) begin
      failures++;
      $display("[TB] FAIL b2b_valids got=%0d want=%0d", valid_cnt - v0, 2);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, n;
    logic [DW+7:0] obs, exp;
    logic [DW-1:0] sw;
    v0 = valid_cnt;
    send(MODE0.cpol, MODE0.cpha, 1, 24, 0, DW'($urandom), DW'($urandom), 1'b0);
    n = 0;
    while (edge_cnt < 10 && n < 500) begin
      tick();
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    obs = {cs, spi_clk, mosi, o_ready, o_miso_valid, o_spi_state, o_miso_data};
    exp = {2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, {DW{1'b0}}};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    repeat (300) tick();
    checks++;
    if (valid_cnt != v0) begin
      failures++;
      $display("[TB] FAIL midreset_no_valid got=%0d want=%0d", valid_cnt - v0, 0);
    end
    sw = DW'($urandom);
    send(MODE3.cpol, MODE3.cpha, 2, 16, 1, 24'h00BEEF, sw, 1'b0);
    wait_valid(v0 + 1);
    checks++;
    if ((rx_at_valid !== (sw & lmask(16))) || (slave_rx !== 24'h00BEEF)) begin
      failures++;
      $display("[TB] FAIL midreset_next_frame got=%h/%h want=%h/00beef",
               rx_at_valid, slave_rx, sw & lmask(16));
    end
  endtask

  task automatic test_cs_sel_clamp();
    int v0;
    v0 = valid_cnt;
    send(MODE0.cpol, MODE0.cpha, 0, 4, 3, 24'h00000C, 24'h000005, 1'b0);
    repeat (2) tick();
    checks++;
    if (cs !== 2'b01) begin
      failures++;
      $display("[TB] FAIL cs_clamp got=%b want=01", cs);
    end
    wait_valid(v0 + 1);
    checks++;
    if ((cs_bad != 0) || (rx_at_valid !== 24'h000005)) begin
      failures++;
      $display("[TB] FAIL cs_clamp_frame got=%0d/%h want=0/000005", cs_bad, rx_at_valid);
    end
  endtask

  task automatic test_config_change();
    int v0;
    logic [DW-1:0] d, sw;
    v0 = valid_cnt;
    d  = DW'($urandom);
    sw = DW'($urandom);
    send(MODE0.cpol, MODE0.cpha, 2, 12, 0, d, sw, 1'b0);
    repeat (20) tick();
    cpol      = 1'b1;
    cpha      = 1'b1;
    div       = 8'd0;
    len       = 5'd3;
    cs_sel    = 1'b1;
    mosi_data = ~d;
    wait_valid(v0 + 1);
    checks++;
    if ((cs_low_cyc != frame_cycles(2, 12)) || (edge_cnt != 24) || (cs_bad != 0)) begin
      failures++;
      $display("[TB] FAIL cfg_change_timing got=%0d/%0d/%0d want=%0d/24/0",
               cs_low_cyc, edge_cnt, cs_bad, frame_cycles(2, 12));
    end
    checks++;
    if ((rx_at_valid !== (sw & lmask(12))) || (slave_rx !== (d & lmask(12))) ||
        (sclk_at_valid !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL cfg_change_data got=%h/%h/%b want=%h/%h/0",
               rx_at_valid, slave_rx, sclk_at_valid, sw & lmask(12), d & lmask(12));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int v0, d, l, s;
      logic pol, pha;
      logic [DW-1:0] data, sw;
      v0   = valid_cnt;
      pol  = 1'($urandom);
      pha  = 1'($urandom);
      d    = int'($urandom_range(0, 3));
      l    = int'($urandom_range(0, 31));
      s    = int'($urandom_range(0, 3));
      data = DW'($urandom);
      sw   = DW'($urandom);
      send(pol, pha, d, l, s, data, sw, 1'b0);
      wait_valid(v0 + 1);
      checks++;
      if ((rx_at_valid !== (sw & lmask(leff(l)))) || (slave_rx !== (data & lmask(leff(l))))) begin
        failures++;
        $display("[TB] FAIL rand%0d_data got=%h/%h want=%h/%h", i, rx_at_valid, slave_rx,
                 sw & lmask(leff(l)), data & lmask(leff(l)));
      end
      checks++;
      if ((cs_low_cyc != frame_cycles(d, l)) || (edge_cnt != 2 * leff(l)) ||
          (cs_bad != 0) || (sclk_at_valid !== pol)) begin
        failures++;
        $display("[TB] FAIL rand%0d_timing got=%0d/%0d/%0d/%b want=%0d/%0d/0/%b", i,
                 cs_low_cyc, edge_cnt, cs_bad, sclk_at_valid,
                 frame_cycles(d, l), 2 * leff(l), pol);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_mode2_loopback();
    test_mode1();
    test_back_to_back();
    test_reset_midframe();
    test_cs_sel_clamp();
    test_config_change();
    test_random();
    checks++;
    if (mosi_idle_bad != 0) begin
      failures++;
      $display("[TB] FAIL mosi_idle got=%0d cycles want=0", mosi_idle_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
# spi_master_mc

Parametrised SPI master, successor to the fixed-mode DAC8563 link. Adds runtime-selectable CPOL/CPHA, a runtime clock divider, per-frame bit length, and multiple chip selects, so the DAC, ADC and auxiliary SPI devices on one board share a single master. It sits between the register/control logic (valid/ready command side) and the board SPI pins.

## Interface
- DATA_WIDTH, 24: maximum frame length in bits.
- NUM_CS, 2: number of chip-select outputs (≥1).
- DIV_WIDTH, 8: width of the runtime divider.
- DELAY, 5: CS setup and CS hold time in clocks (≥1).
- CSW = max(1, $clog2(NUM_CS)); LW = $clog2(DATA_WIDTH+1).

- i_clk  in  1  system clock (5 ns).
- i_fRST  in  1  reset; one clock; reset is synchronous and active-high.
- i_spi_start  in  1  command valid.
- o_ready  out  1  command accepted when i_spi_start && o_ready.
- i_cs_sel  in  CSW  target slave index.
- i_cpol  in  1  clock idle level.
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- i_div  in  DIV_WIDTH  half-period = i_div+1 clocks.
- i_len  in  LW  frame length L; 0 or >DATA_WIDTH means DATA_WIDTH.
- i_mosi_data  in  DATA_WIDTH  TX data, bits [L-1:0] sent MSB first.
- miso  in  1  SPI MISO pin.
- o_miso_data  out  DATA_WIDTH  last RX frame, right-aligned, zero-extended.
- o_miso_valid  out  1  one-cycle strobe when o_miso_data updates.
- mosi  out  1  SPI MOSI pin.
- cs  out  NUM_CS  active-low chip selects.
- spi_clk  out  1  SPI clock pin.
- o_spi_state  out  3  current FSM state.

## Operation
- States: IDLE=0, SETUP=1, SHIFT=2, HOLD=3, DONE=4. Other encodings go to IDLE.
- IDLE: o_ready=1. On accept, latch i_cs_sel, i_cpol, i_cpha, i_div, L and TX data, then go to SETUP. Inputs are ignored until the next IDLE.
- i_cs_sel ≥ NUM_CS selects cs[NUM_CS-1].
- SETUP (DELAY clocks):
  - Selected cs is low and spi_clk = latched CPOL.
  - If CPHA=0, mosi presents bit L-1.
- SHIFT (2L half-periods, i_div+1 clocks each): spi_clk toggles at the end of each half-period, 2L toggles in total, ending at CPOL.
  - CPHA=0: sample miso on odd toggles (leading edges); advance mosi on even toggles, except the last.
  - CPHA=1: advance mosi on odd toggles (the first one presents bit L-1); sample miso on even toggles.
- HOLD (DELAY clocks): cs stays low and spi_clk = CPOL.
- DONE (1 clock):
  - All cs are high.
  - o_miso_data <= received L bits, first-sampled bit at position L-1, upper bits 0.
  - o_miso_valid = 1.
  - Next state is IDLE.
- mosi = 0 whenever no cs is asserted. No tri-state.
- Reset values:
  - state IDLE, o_ready 1, cs all 1, spi_clk 0, mosi 0.
  - o_miso_data 0, o_miso_valid 0, o_spi_state 0.
- Reset mid-frame: every output takes its reset value at that edge. No o_miso_valid pulse. The aborted command is dropped.

## Timing
- Accept at edge t0 → SETUP from t0. SHIFT starts at t0+DELAY.
- Toggle k (1..2L) occurs at t0+DELAY+k·(i_div+1). Toggle 2L coincides with entry to HOLD.
- DONE / o_miso_valid in cycle t0+2·DELAY+2L·(i_div+1). o_ready returns 1 cycle later.
- Back-to-back: i_spi_start held high is accepted in that IDLE cycle. Minimum cs-high gap between frames is 2 clocks.
- miso is sampled with the same i_clk edge that produces the sampling spi_clk edge. No extra synchroniser inside the block.
- o_miso_data holds its value until the next DONE.

## Structure
- Package spi_master_pkg holds:
  - the state encodings (IDLE..DONE) and the 3-bit state width;
  - the default DELAY;
  - CPOL/CPHA mode constants (MODE0..MODE3).
- Sub-module spi_clk_gen: half-period counter plus toggle counter. It outputs spi_clk, lead/trail edge strobes and a done flag. It is started and cleared by the FSM.
- The top level holds the FSM, TX/RX shift registers, CS decode and output registers.

## Test plan
- Mode 2 (CPOL=1, CPHA=0), div=3, L=0 (→24), cs_sel=0, data 0x188000, miso looped to mosi:
  - cs[0] low for 202 clocks;
  - 24 falling-leading edges;
  - o_miso_data=0x188000 with a single o_miso_valid.
- Mode 1 (CPOL=0, CPHA=1), div=0, L=8, cs_sel=1, data 0xA5, miso tied 1:
  - mosi shows 1,0,1,0,0,1,0,1 on rising edges;
  - o_miso_data=0x0000FF;
  - cs[0] stays high throughout.
- Two commands with i_spi_start held high (0x123456, then 0x654321, mode 0): both frames are sent, with exactly a 2-clock cs-high gap and two valid strobes.
- Assert i_fRST for 1 clock in mid-SHIFT (toggle 10):
  - next edge: cs all 1, spi_clk 0, state 0, no valid;
  - a following command completes normally.
- i_cs_sel=3 with NUM_CS=2: cs[1] is asserted.
- Changing i_cpol or i_div mid-frame has no effect on the frame in flight.
